id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/PC/immediate width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter NUM_SRC, default 2, number of source operands carried.
REQ-004 SHALL have parameter NUM_WB, default 2, number of writeback snoop ports; port 0 has highest priority.
REQ-005 SHALL have parameter CTRL_W, default 10, width of the packed control bundle.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-007 SHALL have these ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID holds a valid instruction
- in_ready  out  1  block accepts the ID payload this edge
- in_ctrl  in  CTRL_W  decoded control bundle
- in_pc  in  DATA_W  next PC
- in_src_addr  in  NUM_SRC*ADDR_W  source register addresses
- in_src_data  in  NUM_SRC*DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_rd  in  ADDR_W  destination address
- flush  in  1  squash all held and incoming instructions
- wb_en  in  NUM_WB  writeback port enables
- wb_addr  in  NUM_WB*ADDR_W  writeback addresses
- wb_data  in  NUM_WB*DATA_W  writeback data
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX consumes the payload this edge
- out_ctrl, out_pc, out_src_addr, out_src_data, out_imm, out_rd  out  same widths  registered payload

Function
REQ-008 SHALL hold two entries, main and skid, controlled by states EMPTY, FULL, SKID.
REQ-009 SHALL drive in_ready = 1 in EMPTY and FULL and 0 in SKID, from registered state only.
REQ-010 SHALL drive out_valid = 1 in FULL and SKID; out_* SHALL always present the main entry.
REQ-011 EMPTY: in_valid -> main <= input, FULL.
REQ-012 FULL: in_valid & out_ready -> main <= input, stay FULL; in_valid & !out_ready -> skid <= input, SKID; !in_valid & out_ready -> EMPTY; otherwise hold.
REQ-013 SKID: out_ready -> main <= skid, FULL; otherwise hold both.
REQ-014 flush SHALL force EMPTY on the next edge from any state, discard any same-edge input, and keep in_ready = 1 during flush unless the state is SKID.
REQ-015 On capture, each source operand i SHALL take wb_data of the lowest-index port with wb_en set and wb_addr == in_src_addr[i], else in_src_data[i].
REQ-016 Every edge, operands held in main and skid SHALL be updated by the same matching rule against their stored address; the payload is otherwise unchanged.
REQ-017 Address 0 SHALL never match a writeback.
REQ-018 Throughput SHALL be one instruction per cycle with out_ready held high; latency from accept to out_valid is one edge.
REQ-019 Payload fields other than operands SHALL pass unmodified; no arithmetic is performed.

Reset
REQ-020 reset low SHALL immediately set state EMPTY, out_valid 0, in_ready 1, and all payload registers, both entries, to zero.
REQ-021 Reset asserted mid-transfer SHALL drop both entries; the first edge after release behaves as EMPTY.

Structure
REQ-022 State encoding, default parameter values, and the control-bundle field layout SHALL live in the shared pipeline package.
REQ-023 Operand bypass SHALL be one sub-module, wb_bypass_mux (one operand, NUM_WB ports), instantiated NUM_SRC x 3 (capture, main, skid).

Verification
REQ-024 Reset low with in_valid 1 -> out_valid 0, out_pc 0; after release one edge with in_pc 0x40 -> out_valid 1, out_pc 0x40.
REQ-025 Back-pressure: accept A (pc 0x10), out_ready 0, then B (pc 0x14) -> in_ready 0, out_pc 0x10; out_ready 1 -> out_pc 0x14, in_ready 1.
REQ-026 Capture bypass: in_src_addr[0] 3, in_src_data 0x1111; wb_en 2'b11, wb_addr 3 and 3, wb_data 0xAAAA and 0xBBBB -> out_src_data[0] 0xAAAA.
REQ-027 Held bypass: main stalled with src addr 7; wb_en[1] 1, wb_addr 7, wb_data 0xCAFE -> out_src_data 0xCAFE next edge; wb_addr 0 never alters data.
REQ-028 Flush in SKID with in_valid 1 -> next edge out_valid 0, in_ready 1, neither entry nor input emerges.
REQ-029 Streaming 8 instructions, out_ready 1 -> 8 consecutive outputs in order, no bubbles.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline package for the ID/EX stage register.
// Holds the two-entry buffer state encoding, the default datapath widths
// and the layout of the packed decoded-control bundle carried from ID to EX.
package id_ex_stage_reg_pkg;

  localparam int PIPE_DATA_W  = 32;
  localparam int PIPE_ADDR_W  = 5;
  localparam int PIPE_NUM_SRC = 2;
  localparam int PIPE_NUM_WB  = 2;

  // Control bundle, MSB first. Carried untouched through the stage.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);

  // EMPTY: nothing held. FULL: main holds an instruction.
  // SKID: main and skid both hold instructions; ID is stalled.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/id_ex_stage_reg_wb_bypass_mux.sv
// Writeback bypass for one source operand.
// Ports:
//   src_addr  in  ADDR_W         register address of the operand
//   src_data  in  DATA_W         current operand value
//   wb_en     in  NUM_WB         writeback port enables
//   wb_addr   in  NUM_WB*ADDR_W  writeback addresses (port 0 in low bits)
//   wb_data   in  NUM_WB*DATA_W  writeback data (port 0 in low bits)
//   byp_data  out DATA_W         operand after bypass
// The lowest-index enabled port whose address matches wins; register 0 is
// hard-wired and never takes writeback data.
module wb_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WB = 2
) (
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [DATA_W-1:0]        src_data,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0]        byp_data
);

  // Walk from the highest port down so the lowest matching port is applied last.
  always_comb begin
    byp_data = src_data;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_en[i] && (src_addr != '0) && (wb_addr[i*ADDR_W +: ADDR_W] == src_addr)) begin
        byp_data = wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register with a one-deep skid buffer and
// writeback snooping on the carried source operands.
// State updates on the falling clock edge; reset is asynchronous, active-low.
// Ports:
//   clk, reset                      clock (falling edge active), async active-low reset
//   in_valid / in_ready             ID handshake; in_ready comes from registered state only
//   in_ctrl, in_pc, in_src_addr,
//   in_src_data, in_imm, in_rd      ID payload (operands packed, operand 0 in low bits)
//   flush                           squash held and incoming instructions
//   wb_en, wb_addr, wb_data         writeback snoop ports, port 0 highest priority
//   out_valid / out_ready           EX handshake
//   out_ctrl ... out_rd             registered payload, always the main entry
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int ADDR_W  = PIPE_ADDR_W,
  parameter int NUM_SRC = PIPE_NUM_SRC,
  parameter int NUM_WB  = PIPE_NUM_WB,
  parameter int CTRL_W  = CTRL_BUNDLE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [NUM_SRC*ADDR_W-1:0] in_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [ADDR_W-1:0]         in_rd,
  input  logic                      flush,
  input  logic [NUM_WB-1:0]         wb_en,
  input  logic [NUM_WB*ADDR_W-1:0]  wb_addr,
  input  logic [NUM_WB*DATA_W-1:0]  wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_W-1:0]         out_pc,
  output logic [NUM_SRC*ADDR_W-1:0] out_src_addr,
  output logic [NUM_SRC*DATA_W-1:0] out_src_data,
  output logic [DATA_W-1:0]         out_imm,
  output logic [ADDR_W-1:0]         out_rd
);

  buf_state_e state, state_nxt;
  logic       load_main_in;
  logic       load_main_skid;
  logic       load_skid_in;

  // Main entry (presented to EX) and skid entry.
  logic [CTRL_W-1:0]         main_ctrl_p1,     skid_ctrl_p1;
  logic [DATA_W-1:0]         main_pc_p1,       skid_pc_p1;
  logic [NUM_SRC*ADDR_W-1:0] main_src_addr_p1, skid_src_addr_p1;
  logic [NUM_SRC*DATA_W-1:0] main_src_data_p1, skid_src_data_p1;
  logic [DATA_W-1:0]         main_imm_p1,      skid_imm_p1;
  logic [ADDR_W-1:0]         main_rd_p1,       skid_rd_p1;
  logic                      vld_p1;

  // Bypassed operands: incoming, held in main, held in skid.
  logic [NUM_SRC*DATA_W-1:0] cap_src_data_p0;
  logic [NUM_SRC*DATA_W-1:0] main_byp_data_p0;
  logic [NUM_SRC*DATA_W-1:0] skid_byp_data_p0;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) u_cap_byp (
      .src_addr (in_src_addr[s*ADDR_W +: ADDR_W]),
      .src_data (in_src_data[s*DATA_W +: DATA_W]),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .byp_data (cap_src_data_p0[s*DATA_W +: DATA_W])
    );

    wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) u_main_byp (
      .src_addr (main_src_addr_p1[s*ADDR_W +: ADDR_W]),
      .src_data (main_src_data_p1[s*DATA_W +: DATA_W]),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .byp_data (main_byp_data_p0[s*DATA_W +: DATA_W])
    );

    wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) u_skid_byp (
      .src_addr (skid_src_addr_p1[s*ADDR_W +: ADDR_W]),
      .src_data (skid_src_data_p1[s*DATA_W +: DATA_W]),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .byp_data (skid_byp_data_p0[s*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_valid) begin
            load_main_in = 1'b1;
            state_nxt    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_valid) begin
            load_skid_in = 1'b1;
            state_nxt    = ST_SKID;
          end else if (out_ready) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_FULL;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p0 -> p1: main entry ----
  // Held operands keep snooping writeback every edge, even while stalled.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      main_ctrl_p1     <= '0;
      main_pc_p1       <= '0;
      main_src_addr_p1 <= '0;
      main_src_data_p1 <= '0;
      main_imm_p1      <= '0;
      main_rd_p1       <= '0;
    end else if (load_main_in) begin
      main_ctrl_p1     <= in_ctrl;
      main_pc_p1       <= in_pc;
      main_src_addr_p1 <= in_src_addr;
      main_src_data_p1 <= cap_src_data_p0;
      main_imm_p1      <= in_imm;
      main_rd_p1       <= in_rd;
    end else if (load_main_skid) begin
      main_ctrl_p1     <= skid_ctrl_p1;
      main_pc_p1       <= skid_pc_p1;
      main_src_addr_p1 <= skid_src_addr_p1;
      main_src_data_p1 <= skid_byp_data_p0;
      main_imm_p1      <= skid_imm_p1;
      main_rd_p1       <= skid_rd_p1;
    end else begin
      main_src_data_p1 <= main_byp_data_p0;
    end
  end

  // ---- stage p0 -> p1: skid entry ----
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      skid_ctrl_p1     <= '0;
      skid_pc_p1       <= '0;
      skid_src_addr_p1 <= '0;
      skid_src_data_p1 <= '0;
      skid_imm_p1      <= '0;
      skid_rd_p1       <= '0;
    end else if (load_skid_in) begin
      skid_ctrl_p1     <= in_ctrl;
      skid_pc_p1       <= in_pc;
      skid_src_addr_p1 <= in_src_addr;
      skid_src_data_p1 <= cap_src_data_p0;
      skid_imm_p1      <= in_imm;
      skid_rd_p1       <= in_rd;
    end else begin
      skid_src_data_p1 <= skid_byp_data_p0;
    end
  end

  // ---- p1 outputs ----
  assign vld_p1       = (state == ST_FULL) || (state == ST_SKID);
  assign in_ready     = (state != ST_SKID);
  assign out_valid    = vld_p1;
  assign out_ctrl     = main_ctrl_p1;
  assign out_pc       = main_pc_p1;
  assign out_src_addr = main_src_addr_p1;
  assign out_src_data = main_src_data_p1;
  assign out_imm      = main_imm_p1;
  assign out_rd       = main_rd_p1;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NW = 2;
  localparam int CW = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_ctrl = '0;
  logic [DW-1:0]    in_pc = '0;
  logic [NS*AW-1:0] in_src_addr = '0;
  logic [NS*DW-1:0] in_src_data = '0;
  logic [DW-1:0]    in_imm = '0;
  logic [AW-1:0]    in_rd = '0;
  logic             flush = 1'b0;
  logic [NW-1:0]    wb_en = '0;
  logic [NW*AW-1:0] wb_addr = '0;
  logic [NW*DW-1:0] wb_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_ctrl;
  logic [DW-1:0]    out_pc;
  logic [NS*AW-1:0] out_src_addr;
  logic [NS*DW-1:0] out_src_data;
  logic [DW-1:0]    out_imm;
  logic [AW-1:0]    out_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_pc        (in_pc),
    .in_src_addr  (in_src_addr),
    .in_src_data  (in_src_data),
    .in_imm       (in_imm),
    .in_rd        (in_rd),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_pc       (out_pc),
    .out_src_addr (out_src_addr),
    .out_src_data (out_src_data),
    .out_imm      (out_imm),
    .out_rd       (out_rd)
  );

  typedef struct packed {
    logic [CW-1:0]    ctrl;
    logic [DW-1:0]    pc;
    logic [NS*AW-1:0] sa;
    logic [NS*DW-1:0] sd;
    logic [DW-1:0]    imm;
    logic [AW-1:0]    rd;
  } ent_t;

  // Model: an ordered queue of at most two instructions.
  ent_t q[$];

  function automatic logic [DW-1:0] byp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int p = 0; p < NW; p++) begin
      if (wb_en[p] && (a != 0) && (wb_addr[p*AW +: AW] == a)) return wb_data[p*DW +: DW];
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk or negedge reset) begin : mdl
    ent_t e;
    ent_t h;
    int   n;
    if (!reset) begin
      q.delete();
    end else begin
      e.ctrl = in_ctrl;
      e.pc   = in_pc;
      e.sa   = in_src_addr;
      e.imm  = in_imm;
      e.rd   = in_rd;
      for (int s = 0; s < NS; s++)
        e.sd[s*DW +: DW] = byp(in_src_addr[s*AW +: AW], in_src_data[s*DW +: DW]);
      for (int k = 0; k < q.size(); k++) begin
        h = q[k];
        for (int s = 0; s < NS; s++)
          h.sd[s*DW +: DW] = byp(h.sa[s*AW +: AW], h.sd[s*DW +: DW]);
        q[k] = h;
      end
      n = q.size();
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) q.push_back(e);
      end
    end
  end

  // Compare process: outputs are stable at the rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_payload_zero",
          64'(|{out_ctrl, out_pc, out_src_addr, out_src_data, out_imm, out_rd}), 64'(0));
    end else begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0 && out_valid) begin
        chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
        chk("out_pc", 64'(out_pc), 64'(q[0].pc));
        chk("out_src_addr", 64'(out_src_addr), 64'(q[0].sa));
        chk("out_src_data", 64'(out_src_data), 64'(q[0].sd));
        chk("out_imm", 64'(out_imm), 64'(q[0].imm));
        chk("out_rd", 64'(out_rd), 64'(q[0].rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a valid instruction waiting.
    in_valid = 1'b1;
    in_pc    = 32'h40;
    tick();
    tick();
    chk("lit_rst_valid", 64'(out_valid), 64'(0));
    chk("lit_rst_pc", 64'(out_pc), 64'(0));
    reset = 1'b1;
    tick();
    chk("lit_first_valid", 64'(out_valid), 64'(1));
    chk("lit_first_pc", 64'(out_pc), 64'h40);

    // Back-pressure into the skid entry.
    in_valid = 1'b0; out_ready = 1'b1; tick();
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h10; tick();
    in_pc = 32'h14; tick();
    chk("lit_bp_in_ready", 64'(in_ready), 64'(0));
    chk("lit_bp_pc_a", 64'(out_pc), 64'h10);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("lit_bp_pc_b", 64'(out_pc), 64'h14);
    chk("lit_bp_ready", 64'(in_ready), 64'(1));
    tick();

    // Capture bypass: both ports match, port 0 wins.
    in_valid    = 1'b1; out_ready = 1'b0; in_pc = 32'h20;
    in_src_addr = {5'd0, 5'd3};
    in_src_data = {32'h0, 32'h1111};
    wb_en       = 2'b11;
    wb_addr     = {5'd3, 5'd3};
    wb_data     = {32'hBBBB, 32'hAAAA};
    tick();
    chk("lit_cap_byp", 64'(out_src_data[DW-1:0]), 64'hAAAA);

    // Held bypass on a stalled main entry; address 0 never matches.
    wb_en = 2'b00; in_valid = 1'b0; out_ready = 1'b1; tick();
    in_valid    = 1'b1; out_ready = 1'b0; in_pc = 32'h30;
    in_src_addr = {5'd0, 5'd7};
    in_src_data = {32'h2222, 32'h1234};
    tick();
    chk("lit_held_pre", 64'(out_src_data), {32'h2222, 32'h1234});
    in_valid = 1'b0;
    wb_en    = 2'b10;
    wb_addr  = {5'd7, 5'd0};
    wb_data  = {32'hCAFE, 32'h5555};
    tick();
    chk("lit_held_byp", 64'(out_src_data[DW-1:0]), 64'hCAFE);
    wb_en   = 2'b11;
    wb_addr = {5'd0, 5'd0};
    wb_data = {32'hDEAD, 32'hBEEF};
    tick();
    chk("lit_addr0", 64'(out_src_data), {32'h2222, 32'hCAFE});
    wb_en = 2'b00;

    // Flush while in SKID with an incoming instruction.
    in_valid = 1'b1; in_pc = 32'h50; tick();
    chk("lit_skid_ready", 64'(in_ready), 64'(0));
    flush = 1'b1; in_pc = 32'h60; tick();
    chk("lit_flush_valid", 64'(out_valid), 64'(0));
    chk("lit_flush_ready", 64'(in_ready), 64'(1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("lit_flush_empty", 64'(out_valid), 64'(0));

    // Streaming with no bubbles.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h100 + 32'(4 * i);
      tick();
      chk("lit_stream_valid", 64'(out_valid), 64'(1));
      chk("lit_stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    tick();

    // Randomized traffic with snooping, flushes and a mid-run reset.
    for (int it = 0; it < 3000; it++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      in_ctrl   = CW'($urandom);
      in_pc     = $urandom;
      in_imm    = $urandom;
      in_rd     = AW'($urandom_range(0, 31));
      for (int s = 0; s < NS; s++) begin
        in_src_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
        in_src_data[s*DW +: DW] = $urandom;
      end
      wb_en = NW'($urandom);
      for (int p = 0; p < NW; p++) begin
        wb_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wb_data[p*DW +: DW] = $urandom;
      end
      if (it == 1500) reset = 1'b0;
      if (it == 1502) reset = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
